// File: rtl/jtag_gpios_rmw.sv
// JTAG-controlled GPIO block: DATA/CONFIG/EDGE scan registers with write/set/clear ops,
// synchronised pad inputs and sticky any-edge capture, all clocked by tck.
module jtag_gpios_rmw #(
  parameter int                  NR_GPIOS      = 8,
  parameter int                  SYNC_STAGES   = 2,
  parameter logic [NR_GPIOS-1:0] OUT_RESET_VAL = '0
) (
  input  logic                tck,
  input  logic                reset_,
  input  logic                tdi,
  output logic                gpios_tdo,
  input  logic                capture_dr,
  input  logic                shift_dr,
  input  logic                update_dr,
  input  logic                gpio_data_ir,
  input  logic                gpio_config_ir,
  input  logic                gpio_edge_ir,
  input  logic [NR_GPIOS-1:0] gpio_inputs,
  output logic [NR_GPIOS-1:0] gpio_outputs,
  output logic [NR_GPIOS-1:0] gpio_outputs_ena,
  output logic                gpio_edge_pending
);

  localparam int DRW = NR_GPIOS + 2;

  logic [SYNC_STAGES-1:0][NR_GPIOS-1:0] sync_q;
  logic [NR_GPIOS-1:0] sync_in;
  logic [NR_GPIOS-1:0] prev;
  logic [NR_GPIOS-1:0] edge_q;
  logic [NR_GPIOS-1:0] edge_base;
  logic [NR_GPIOS-1:0] edge_seen;
  logic [NR_GPIOS-1:0] cap_src;
  logic [NR_GPIOS-1:0] payload;
  logic [1:0]          op;
  logic [DRW-1:0]      dr;
  logic                sel_data;
  logic                sel_config;
  logic                sel_edge;
  logic                any_ir;
  logic                do_update;

  function automatic logic [NR_GPIOS-1:0] apply_op(
    input logic [1:0]          o,
    input logic [NR_GPIOS-1:0] cur,
    input logic [NR_GPIOS-1:0] p
  );
    logic [NR_GPIOS-1:0] r;
    r = cur;
    case (o)
      2'b01:   r = p;
      2'b10:   r = cur | p;
      2'b11:   r = cur & ~p;
      default: r = cur;
    endcase
    return r;
  endfunction

  assign sync_in    = sync_q[SYNC_STAGES-1];
  assign edge_seen  = sync_in ^ prev;

  // data > config > edge when several instructions are active at once
  assign sel_data   = gpio_data_ir;
  assign sel_config = !gpio_data_ir && gpio_config_ir;
  assign sel_edge   = !gpio_data_ir && !gpio_config_ir && gpio_edge_ir;
  assign any_ir     = gpio_data_ir || gpio_config_ir || gpio_edge_ir;

  assign op         = dr[DRW-1:NR_GPIOS];
  assign payload    = dr[NR_GPIOS-1:0];
  assign do_update  = update_dr && !capture_dr && !shift_dr && any_ir;
  assign gpios_tdo  = dr[0];

  always_comb begin
    cap_src = edge_q;
    if (sel_data)
      cap_src = sync_in;
    else if (sel_config)
      cap_src = gpio_outputs_ena;
  end

  always_comb begin
    edge_base = edge_q;
    if (do_update && sel_edge)
      edge_base = apply_op(op, edge_q, payload);
  end

  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_) begin
      sync_q <= '0;
      prev   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_inputs};
      prev   <= sync_in;
    end
  end

  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_) begin
      dr <= '0;
    end else if (any_ir) begin
      if (capture_dr)
        dr <= {2'b00, cap_src};
      else if (shift_dr)
        dr <= {tdi, dr[DRW-1:1]};
    end
  end

  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_) begin
      gpio_outputs     <= OUT_RESET_VAL;
      gpio_outputs_ena <= '0;
    end else if (do_update) begin
      if (sel_data)
        gpio_outputs <= apply_op(op, gpio_outputs, payload);
      if (sel_config)
        gpio_outputs_ena <= apply_op(op, gpio_outputs_ena, payload);
    end
  end

  // a freshly detected edge overrides a clear/write-0 in the same cycle
  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_) begin
      edge_q            <= '0;
      gpio_edge_pending <= 1'b0;
    end else begin
      edge_q            <= edge_base | edge_seen;
      gpio_edge_pending <= |edge_q;
    end
  end

endmodule

// File: tb/tb_jtag_gpios_rmw.sv
// Bench for jtag_gpios_rmw: directed scans plus randomized TAP traffic against a scan-level model.
module tb_jtag_gpios_rmw;

  localparam int N = 8;
  localparam int S = 2;
  localparam int W = N + 2;
  localparam logic [N-1:0] RST_VAL = 8'hA5;

  logic         tck = 1'b0;
  logic         reset_;
  logic         tdi;
  logic         gpios_tdo;
  logic         capture_dr;
  logic         shift_dr;
  logic         update_dr;
  logic         data_ir;
  logic         cfg_ir;
  logic         edge_ir;
  logic [N-1:0] gpio_inputs;
  logic [N-1:0] gpio_outputs;
  logic [N-1:0] gpio_outputs_ena;
  logic         gpio_edge_pending;

  int checks   = 0;
  int failures = 0;

  // Reference state: dr as a bit queue (index 0 = tdo), inputs as a delay line.
  logic         mdr[$];
  logic [N-1:0] pipe[$];
  logic [N-1:0] m_out;
  logic [N-1:0] m_ena;
  logic [N-1:0] m_edge;
  logic         m_pend;

  jtag_gpios_rmw #(
    .NR_GPIOS     (N),
    .SYNC_STAGES  (S),
    .OUT_RESET_VAL(RST_VAL)
  ) dut (
    .tck              (tck),
    .reset_           (reset_),
    .tdi              (tdi),
    .gpios_tdo        (gpios_tdo),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .gpio_data_ir     (data_ir),
    .gpio_config_ir   (cfg_ir),
    .gpio_edge_ir     (edge_ir),
    .gpio_inputs      (gpio_inputs),
    .gpio_outputs     (gpio_outputs),
    .gpio_outputs_ena (gpio_outputs_ena),
    .gpio_edge_pending(gpio_edge_pending)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] rmw(input logic [1:0] op, input logic [N-1:0] cur,
                                       input logic [N-1:0] p);
    if (op == 2'd1) return p;
    if (op == 2'd2) return cur | p;
    if (op == 2'd3) return cur & ~p;
    return cur;
  endfunction

  task automatic m_reset();
    mdr = {};
    for (int i = 0; i < W; i++) mdr.push_back(1'b0);
    pipe = {};
    for (int i = 0; i <= S; i++) pipe.push_back('0);
    m_out  = RST_VAL;
    m_ena  = '0;
    m_edge = '0;
    m_pend = 1'b0;
  endtask

  // Advance the model by one tck rising edge, using the inputs currently driven.
  task automatic model_edge();
    logic [N-1:0] sync;
    logic [N-1:0] det;
    logic [N-1:0] src;
    logic [N-1:0] p;
    logic [N-1:0] nxt_edge;
    logic [1:0]   op;
    logic         pend_n;
    int           sel;
    sel      = data_ir ? 0 : cfg_ir ? 1 : edge_ir ? 2 : 3;
    sync     = pipe[1];
    det      = pipe[0] ^ pipe[1];
    nxt_edge = m_edge;
    pend_n   = |m_edge;
    if (sel != 3) begin
      if (capture_dr) begin
        src = (sel == 0) ? sync : (sel == 1) ? m_ena : m_edge;
        mdr = {};
        for (int i = 0; i < N; i++) mdr.push_back(src[i]);
        mdr.push_back(1'b0);
        mdr.push_back(1'b0);
      end else if (shift_dr) begin
        void'(mdr.pop_front());
        mdr.push_back(tdi);
      end else if (update_dr) begin
        for (int i = 0; i < N; i++) p[i] = mdr[i];
        op = {mdr[N+1], mdr[N]};
        if (sel == 0) m_out = rmw(op, m_out, p);
        if (sel == 1) m_ena = rmw(op, m_ena, p);
        if (sel == 2) nxt_edge = rmw(op, m_edge, p);
      end
    end
    m_edge = nxt_edge | det;
    m_pend = pend_n;
    void'(pipe.pop_front());
    pipe.push_back(gpio_inputs);
  endtask

  task automatic check_all();
    chk("tdo", gpios_tdo, mdr[0]);
    chk("outputs", gpio_outputs, m_out);
    chk("outputs_ena", gpio_outputs_ena, m_ena);
    chk("edge_pending", gpio_edge_pending, m_pend);
  endtask

  task automatic cyc(input logic cap, input logic sh, input logic upd, input logic t);
    capture_dr = cap;
    shift_dr   = sh;
    update_dr  = upd;
    tdi        = t;
    @(posedge tck);
    model_edge();
    @(negedge tck);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Capture, shift len bits, update, one idle. flip toggles inputs so the edge lands on update.
  task automatic scan(input logic [2:0] ir, input logic [1:0] op, input logic [N-1:0] pay,
                      input int len, input logic [N-1:0] flip, output logic [W-1:0] word);
    logic [W-1:0] v;
    logic         b;
    v    = {op, pay};
    word = '0;
    {data_ir, cfg_ir, edge_ir} = ir;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      if (i < W) word[i] = gpios_tdo;
      if (i == len - 2) gpio_inputs = gpio_inputs ^ flip;
      if (len >= W) b = (i < len - W) ? 1'($urandom) : v[i-(len-W)];
      else          b = v[i];
      cyc(1'b0, 1'b1, 1'b0, b);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
  endtask

  // Assert reset between a falling and a rising edge; effect must be immediate.
  task automatic async_reset(input int dly);
    #(dly);
    reset_ = 1'b0;
    #1;
    chk("rst_outputs", gpio_outputs, RST_VAL);
    chk("rst_ena", gpio_outputs_ena, '0);
    chk("rst_tdo", gpios_tdo, 1'b0);
    chk("rst_pending", gpio_edge_pending, 1'b0);
    m_reset();
    @(negedge tck);
    @(negedge tck);
    reset_ = 1'b1;
  endtask

  initial begin
    logic [W-1:0] w;
    reset_      = 1'b0;
    tdi         = 1'b0;
    capture_dr  = 1'b0;
    shift_dr    = 1'b0;
    update_dr   = 1'b0;
    data_ir     = 1'b0;
    cfg_ir      = 1'b0;
    edge_ir     = 1'b0;
    gpio_inputs = '0;
    m_reset();
    @(negedge tck);
    @(negedge tck);
    chk("init_outputs", gpio_outputs, RST_VAL);
    chk("init_ena", gpio_outputs_ena, '0);
    reset_ = 1'b1;
    idle(2);

    // Read-only DATA capture of 3C
    gpio_inputs = 8'h3C;
    idle(4);
    scan(3'b100, 2'b00, 8'h00, W, '0, w);
    chk("read_data", w, 10'h03C);
    chk("data_ro_outputs", gpio_outputs, RST_VAL);

    // CONFIG write / set / clear / readback
    scan(3'b010, 2'b01, 8'hF0, W, '0, w);
    chk("cfg_write", gpio_outputs_ena, 8'hF0);
    scan(3'b010, 2'b10, 8'h0F, W, '0, w);
    chk("cfg_set", gpio_outputs_ena, 8'hFF);
    scan(3'b010, 2'b11, 8'h81, W, '0, w);
    chk("cfg_clear", gpio_outputs_ena, 8'h7E);
    scan(3'b010, 2'b00, 8'h00, W, '0, w);
    chk("cfg_readback", w, 10'h07E);

    // DATA write then read-only scan
    scan(3'b100, 2'b01, 8'h55, W, '0, w);
    chk("data_write", gpio_outputs, 8'h55);
    scan(3'b100, 2'b00, 8'hFF, W, '0, w);
    chk("data_hold", gpio_outputs, 8'h55);

    // Edge capture on input[3]
    gpio_inputs = 8'h00;
    idle(4);
    scan(3'b001, 2'b01, 8'h00, W, '0, w);
    chk("edge_cleared", gpio_edge_pending, 1'b0);
    gpio_inputs = 8'h08;
    idle(S + 1);
    chk("edge_pend_early", gpio_edge_pending, 1'b0);
    idle(1);
    chk("edge_pend_set", gpio_edge_pending, 1'b1);
    scan(3'b001, 2'b00, 8'h00, W, '0, w);
    chk("edge_read", w, 10'h008);
    scan(3'b001, 2'b11, 8'h08, W, '0, w);
    chk("edge_clr_pend", gpio_edge_pending, 1'b0);
    scan(3'b001, 2'b11, 8'h08, W, 8'h08, w);
    chk("edge_wins_pend", gpio_edge_pending, 1'b1);
    scan(3'b001, 2'b00, 8'h00, W, '0, w);
    chk("edge_wins_read", w, 10'h008);

    // data beats config when both are selected
    scan(3'b110, 2'b01, 8'h11, W, '0, w);
    chk("prio_outputs", gpio_outputs, 8'h11);
    chk("prio_ena", gpio_outputs_ena, 8'h7E);

    // Long and short scans
    scan(3'b010, 2'b01, 8'h3A, W + 5, '0, w);
    chk("long_scan_ena", gpio_outputs_ena, 8'h3A);

    // Reset in the middle of a DATA shift
    {data_ir, cfg_ir, edge_ir} = 3'b100;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    async_reset(2);
    idle(3);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) gpio_inputs = N'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: scan(3'($urandom), 2'($urandom), N'($urandom), $urandom_range(4, 14),
                         ($urandom_range(0, 2) == 0) ? N'($urandom) : '0, w);
        4, 5, 6, 7, 8: begin
          {data_ir, cfg_ir, edge_ir} = 3'($urandom);
          cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        default: if ($urandom_range(0, 7) == 0) async_reset($urandom_range(1, 3));
                 else idle(1);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
